// File: rtl/vdisp_scan.sv
// vdisp_scan: 4-digit time-multiplexed scan controller driving a 7-segment decoder.
// Optional leading-zero blanking is enabled by defining VDISP_LZ_BLANK_EN.
module vdisp_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 2,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  x,
  output logic [3:0]  an_L,
  output logic        dp_L,
  output logic        frame_tick,
  output logic        pending
);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      disp;
  logic [15:0]      shadow;
  logic [3:0]       dp_reg;
  logic [3:0]       shadow_dp;

  logic             slot_tick;
  logic             frame_edge;
  logic [3:0]       cur_nib;
  logic [3:0]       sel_L;
  logic [3:0]       shown;
  logic             lit;

  assign slot_tick  = en && (cnt == LAST_CNT);
  assign frame_edge = slot_tick && (idx == 2'd3);

  always_comb begin
    cur_nib = disp[3:0];
    case (idx)
      2'd1:    cur_nib = disp[7:4];
      2'd2:    cur_nib = disp[11:8];
      2'd3:    cur_nib = disp[15:12];
      default: cur_nib = disp[3:0];
    endcase
  end

  always_comb begin
    sel_L      = 4'b1111;
    sel_L[idx] = 1'b0;
  end

  // A digit is suppressed only when it and every more-significant nibble are zero.
  always_comb begin
    shown = 4'b1111;
`ifdef VDISP_LZ_BLANK_EN
    shown[1] = |disp[15:4];
    shown[2] = |disp[15:8];
    shown[3] = |disp[15:12];
`endif
  end

  assign lit = en && (cnt >= GUARD_CNT) && shown[idx];

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (en) begin
      if (slot_tick) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // A load coinciding with the frame boundary bypasses the shadow entirely.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      disp      <= 16'h0000;
      dp_reg    <= 4'h0;
      shadow    <= 16'h0000;
      shadow_dp <= 4'h0;
      pending   <= 1'b0;
    end else begin
      if (load) begin
        shadow    <= value;
        shadow_dp <= dp_in;
      end
      if (frame_edge) begin
        if (load) begin
          disp   <= value;
          dp_reg <= dp_in;
        end else if (pending) begin
          disp   <= shadow;
          dp_reg <= shadow_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      x          <= 4'h0;
      an_L       <= 4'b1111;
      dp_L       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      x          <= cur_nib;
      an_L       <= lit ? sel_L : 4'b1111;
      dp_L       <= ~dp_reg[idx];
      frame_tick <= frame_edge;
    end
  end

endmodule

// File: tb/tb_vdisp_scan.sv
// tb_vdisp_scan: self-checking bench for vdisp_scan with a frame-position reference model.
// Honours VDISP_LZ_BLANK_EN the same way the design does.
module tb_vdisp_scan;

  localparam int SD    = 4;
  localparam int G     = 1;
  localparam int FRAME = 4 * SD;
`ifdef VDISP_LZ_BLANK_EN
  localparam bit LZ_ON = 1'b1;
`else
  localparam bit LZ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_L = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  x;
  logic [3:0]  an_L;
  logic        dp_L;
  logic        frame_tick;
  logic        pending;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  vdisp_scan #(.SCAN_DIV(SD), .GUARD(G), .CNT_W(4)) dut (
    .clk(clk), .rst_L(rst_L), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .x(x), .an_L(an_L), .dp_L(dp_L), .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference model: position within the frame in enabled cycles, plus the word pipeline.
  int          pos;
  logic [15:0] m_disp, m_sh;
  logic [3:0]  m_dp, m_shdp;
  logic        m_pend;
  logic [3:0]  exp_x, exp_an;
  logic        exp_dp, exp_ft;

  function automatic logic [3:0] nib_of(logic [15:0] w, int s);
    return w[4*s +: 4];
  endfunction

  function automatic logic shown_of(logic [15:0] w, int s);
    return !LZ_ON || (s == 0) || ((w >> (4*s)) != 16'h0);
  endfunction

  function automatic logic [3:0] an_for(int s);
    logic [3:0] r;
    r = 4'b1111;
    r[s] = 1'b0;
    return r;
  endfunction

  always @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      pos <= 0; m_disp <= 16'h0; m_dp <= 4'h0; m_sh <= 16'h0; m_shdp <= 4'h0; m_pend <= 1'b0;
      exp_x <= 4'h0; exp_an <= 4'hF; exp_dp <= 1'b1; exp_ft <= 1'b0;
    end else begin
      exp_x  <= nib_of(m_disp, pos / SD);
      exp_dp <= ~m_dp[pos / SD];
      exp_an <= (en && (pos % SD) >= G && shown_of(m_disp, pos / SD)) ? an_for(pos / SD) : 4'hF;
      exp_ft <= en && (pos == FRAME - 1);
      if (en && pos == FRAME - 1) begin
        if (load) begin
          m_disp <= value; m_dp <= dp_in;
        end else if (m_pend) begin
          m_disp <= m_sh; m_dp <= m_shdp;
        end
        m_pend <= 1'b0;
      end else if (load) begin
        m_sh <= value; m_shdp <= dp_in; m_pend <= 1'b1;
      end
      if (en) pos <= (pos + 1) % FRAME;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("x", 16'(x), 16'(exp_x));
      checkOutput("an_L", 16'(an_L), 16'(exp_an));
      checkOutput("dp_L", 16'(dp_L), 16'(exp_dp));
      checkOutput("frame_tick", 16'(frame_tick), 16'(exp_ft));
      checkOutput("pending", 16'(pending), 16'(m_pend));
      checkOutput("an_onehot", 16'($countones(~an_L) <= 1), 16'd1);
    end
  end

  task automatic applyStimulus(input logic e, input logic l, input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    en = e; load = l; value = v; dp_in = d;
  endtask

  task automatic tick(input int n);
    repeat (n) applyStimulus(en, 1'b0, value, dp_in);
  endtask

  task automatic waitFrame();
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (frame_tick) return;
    end
    checkOutput("frame_timeout", 16'd0, 16'd1);
  endtask

  task automatic lzFrame(input logic [15:0] v, input logic [3:0] want_lit);
    logic [3:0] seen;
    applyStimulus(1'b1, 1'b1, v, 4'h0);
    tick(1);
    waitFrame();
    seen = 4'h0;
    for (int k = 1; k <= FRAME; k++) begin
      tick(1);
      seen = seen | ~an_L;
    end
    checkOutput("lz_digits_lit", 16'(seen), 16'(want_lit));
  endtask

  logic [3:0] seq_norm [16] = '{4'hF,4'hE,4'hE,4'hE, 4'hF,4'hD,4'hD,4'hD, 4'hF,4'hB,4'hB,4'hB, 4'hF,4'h7,4'h7,4'h7};
  logic [3:0] seq_lz   [16] = '{4'hF,4'hE,4'hE,4'hE, 4'hF,4'hF,4'hF,4'hF, 4'hF,4'hF,4'hF,4'hF, 4'hF,4'hF,4'hF,4'hF};
  logic [3:0] want_x   [4]  = '{4'hB, 4'hA, 4'h2, 4'h1};
  logic [15:0] masks   [5]  = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

  initial begin
    int cyc;
    #1 rst_L = 1'b0;
    chk_on = 1'b1;

    // Reset hold
    tick(3);
    checkOutput("rst_an_L", 16'(an_L), 16'hF);
    checkOutput("rst_x", 16'(x), 16'h0);
    checkOutput("rst_dp_L", 16'(dp_L), 16'h1);
    checkOutput("rst_frame_tick", 16'(frame_tick), 16'h0);
    checkOutput("rst_pending", 16'(pending), 16'h0);

    // Release and first frame scan pattern
    @(negedge clk);
    rst_L = 1'b1; en = 1'b1;
    for (int n = 1; n <= FRAME; n++) begin
      tick(1);
      checkOutput("scan_an_L", 16'(an_L), 16'(LZ_ON ? seq_lz[n-1] : seq_norm[n-1]));
      checkOutput("scan_tick", 16'(frame_tick), 16'(n == FRAME));
    end

    // Deferred commit
    tick(4);
    applyStimulus(1'b1, 1'b1, 16'h12AB, 4'b0100);
    tick(1);
    checkOutput("defer_pending", 16'(pending), 16'h1);
    checkOutput("defer_x_old", 16'(x), 16'h0);
    waitFrame();
    checkOutput("commit_pending", 16'(pending), 16'h0);
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      if (k % 4 == 1) checkOutput("commit_x", 16'(x), 16'(want_x[k/4]));
      if (k == 9) checkOutput("commit_dp2", 16'(dp_L), 16'h0);
      if (k == 5) checkOutput("commit_dp1", 16'(dp_L), 16'h1);
    end

    // Overwrite: last load wins
    waitFrame();
    applyStimulus(1'b1, 1'b1, 16'h1111, 4'h0);
    applyStimulus(1'b1, 1'b1, 16'h2222, 4'h0);
    tick(1);
    waitFrame();
    tick(1);
    checkOutput("overwrite_x", 16'(x), 16'h2);
    checkOutput("overwrite_pending", 16'(pending), 16'h0);

    // Load on the boundary edge
    tick(13);
    applyStimulus(1'b1, 1'b1, 16'h3333, 4'h0);
    tick(1);
    checkOutput("collide_tick", 16'(frame_tick), 16'h1);
    checkOutput("collide_pending", 16'(pending), 16'h0);
    tick(1);
    checkOutput("collide_x", 16'(x), 16'h3);

    // Enable freeze mid-slot at digit 2
    waitFrame();
    tick(8);
    applyStimulus(1'b0, 1'b0, value, dp_in);
    tick(1);
    checkOutput("freeze_an_L", 16'(an_L), 16'hF);
    tick(8);
    applyStimulus(1'b1, 1'b0, value, dp_in);
    cyc = 19;
    while (!frame_tick && cyc < 80) begin
      tick(1);
      cyc++;
    end
    checkOutput("freeze_period", 16'(cyc), 16'd26);

    // Asynchronous reset while a word is pending and digit 2 is lit
    applyStimulus(1'b1, 1'b1, 16'h4321, 4'hF);
    tick(10);
    checkOutput("pre_rst_an_L", 16'(an_L), 16'hB);
    checkOutput("pre_rst_pending", 16'(pending), 16'h1);
    @(posedge clk);
    #2 rst_L = 1'b0;
    #1;
    checkOutput("arst_an_L", 16'(an_L), 16'hF);
    checkOutput("arst_x", 16'(x), 16'h0);
    checkOutput("arst_dp_L", 16'(dp_L), 16'h1);
    checkOutput("arst_pending", 16'(pending), 16'h0);
    @(negedge clk);
    rst_L = 1'b1;
    waitFrame();
    checkOutput("post_rst_pending", 16'(pending), 16'h0);
    tick(1);
    checkOutput("post_rst_x", 16'(x), 16'h0);

    // Leading-zero behaviour (all digits shown when the feature is off)
    lzFrame(16'h00A5, LZ_ON ? 4'b0011 : 4'b1111);
    lzFrame(16'h0000, LZ_ON ? 4'b0001 : 4'b1111);
    lzFrame(16'h1000, 4'b1111);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 8) != 0, ($urandom % 6) == 0,
                    16'($urandom) & masks[$urandom % 5], 4'($urandom));
    end
    tick(2);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vdisp_scan.md
Name: vdisp_scan

Overview:
- Time-multiplexed 4-digit scan controller sitting directly upstream of the 7-segment decoder.
- Holds a 16-bit display word and rotates through its four nibbles.
- Per digit slot: presents the nibble on x (to the decoder), drives the active-low digit anode select and the decimal point.
- New words are committed only at frame boundaries, so the display never tears.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot (>=2).
- GUARD, 2: blanking cycles at the start of each slot, all anodes off (anti-ghosting); must be < SCAN_DIV.
- CNT_W, 16: prescaler width; must satisfy 2**CNT_W >= SCAN_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_L  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; 0 freezes the scan and blanks all anodes.
- load  in  1  single-cycle strobe; capture value and dp_in into shadow registers.
- value  in  16  display word; nibble k drives digit k (digit 0 = value[3:0], rightmost).
- dp_in  in  4  decimal-point request per digit, 1 = lit.
- x  out  4  nibble of the current digit, feeds decoder input x.
- an_L  out  4  digit select, active low; bit k low = digit k lit.
- dp_L  out  1  decimal point, active low.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- pending  out  1  shadow holds an uncommitted word.

Behaviour:
- Reset, asynchronous on rst_L low. All state clears immediately:
  - cnt=0, idx=0, disp=16'h0000, dp_reg=0, shadow=0, pending=0.
  - x=4'h0, an_L=4'b1111, dp_L=1, frame_tick=0.
- Reset release is taken on the next clk edge. Reset mid-frame discards any pending word.
- Prescaler:
  - When en=1, cnt increments each cycle.
  - At cnt==SCAN_DIV-1 a slot tick occurs: cnt wraps to 0 and idx advances 0->1->2->3->0.
  - When en=0, cnt and idx hold.
- Frame boundary = slot tick while idx==3. On that edge:
  - If pending=1, disp<=shadow, dp_reg<=shadow_dp and pending<=0.
  - frame_tick is registered high for exactly the following cycle.
- Load:
  - load=1 sets shadow<=value, shadow_dp<=dp_in, pending<=1.
  - A load while already pending overwrites the shadow; last load wins.
  - Load on the same edge as a frame boundary commits value/dp_in straight to disp/dp_reg; pending ends 0.
  - Load is accepted regardless of en.
- Outputs are all registered and computed from the pre-edge cnt/idx, so they lag the slot tick by 1 cycle:
  - x <= disp[4*idx +: 4]
  - dp_L <= ~dp_reg[idx]
  - an_L <= (en && cnt>=GUARD) ? ~(4'b0001<<idx) : 4'b1111
- At most one an_L bit is low at any time.
- x updates even while blanked.
- Frame period = 4*SCAN_DIV cycles. Digit k is lit for SCAN_DIV-GUARD cycles per frame.

Optional Feature:
- Macro: VDISP_LZ_BLANK_EN (leading-zero blanking).
- Defined: for each digit k>0, the an_L bit stays high whenever disp nibbles k..3 are all 4'h0. Digit 0 is always shown, so disp=0 displays a single "0".
  - Example: disp=16'h00A5 lights digits 0 and 1 only.
  - Blanked slots still consume their full SCAN_DIV time; frame timing is unchanged.
- Undefined: all four digits are always shown, including leading zeros.

Test Plan:
- Reset and idle, SCAN_DIV=4, GUARD=1:
  - Hold rst_L=0 -> an_L=1111, x=0, dp_L=1, frame_tick=0.
  - Release, en=1 -> an_L sequence per slot is 1111 (1 cycle), 1110 (3); 1111, 1101; 1111, 1011; 1111, 0111; frame_tick pulses every 16 cycles.
- Deferred commit:
  - Mid-frame at idx=1, pulse load with value=16'h12AB, dp_in=4'b0100 -> pending=1 and x keeps showing 0 until the boundary.
  - Next frame shows x = B, A, 2, 1 for digits 0..3, with dp_L=0 only during digit 2; pending returns to 0.
- Overwrite and collision:
  - load 16'h1111, then load 16'h2222 before the boundary -> only 2222 is displayed.
  - Separately, load 16'h3333 exactly on the boundary edge -> committed immediately, pending=0, next frame shows 3.
- Enable freeze:
  - Drop en for 10 cycles mid-slot at idx=2 -> an_L=1111 within 1 cycle, cnt/idx held.
  - Re-raise en -> the slot resumes and completes its remaining cycles; frame period is extended by exactly 10 cycles.
- Async reset mid-operation:
  - Assert rst_L low between clk edges while pending=1 and an_L=1011 -> outputs clear immediately without waiting for a clk edge.
  - After release, disp=0 and pending=0.
- VDISP_LZ_BLANK_EN defined:
  - disp=16'h00A5 -> only an_L bits 0 and 1 ever go low.
  - disp=16'h0000 -> only digit 0 lit, x=0.
  - disp=16'h1000 -> all four digits lit.
